// File: rtl/pes_pump_driver_if.sv
// Pump driver bus: request and flow feedback in, pump drive and status out.
// master = watering controller / plant side, slave = pump driver.
interface pes_pump_driver_if;
    logic       water_pump;
    logic       flow_sensor;
    logic       fault_clear;
    logic       pump_en;
    logic [2:0] pump_state;
    logic       fault;
    logic [1:0] fault_cause;
    logic       timeout_pulse;
    logic [7:0] run_count;

    modport master (
        output water_pump,
        output flow_sensor,
        output fault_clear,
        input  pump_en,
        input  pump_state,
        input  fault,
        input  fault_cause,
        input  timeout_pulse,
        input  run_count
    );

    modport slave (
        input  water_pump,
        input  flow_sensor,
        input  fault_clear,
        output pump_en,
        output pump_state,
        output fault,
        output fault_cause,
        output timeout_pulse,
        output run_count
    );
endinterface

// File: rtl/pes_pump_driver.sv
// Pump actuator driver: min-on / cooldown / max-on enforcement, flow-based
// fault detection with latched cause, and a saturating completed-run count.
module pes_pump_driver #(
    parameter int MIN_ON    = 8,
    parameter int MIN_OFF   = 16,
    parameter int MAX_ON    = 64,
    parameter int FLOW_WAIT = 4
) (
    input logic              clk,
    input logic              reset,
    pes_pump_driver_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_COOL  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [7:0] MIN_ON_C    = 8'(MIN_ON);
    localparam logic [7:0] MIN_OFF_C   = 8'(MIN_OFF);
    localparam logic [7:0] MAX_ON_C    = 8'(MAX_ON);
    localparam logic [7:0] FLOW_WAIT_C = 8'(FLOW_WAIT);

    state_t     state_q, state_d;
    logic [7:0] on_q, on_d;
    logic [7:0] off_q, off_d;
    logic [7:0] runs_q, runs_d;
    logic [7:0] runs_inc;
    logic [1:0] cause_q, cause_d;
    logic       tmo_q, tmo_d;
    logic       sync1_q, flow_s;

    // Flow sensor is asynchronous to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            flow_s  <= 1'b0;
        end else begin
            sync1_q <= bus.flow_sensor;
            flow_s  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            on_q    <= 8'd0;
            off_q   <= 8'd0;
            runs_q  <= 8'd0;
            cause_q <= 2'b00;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            off_q   <= off_d;
            runs_q  <= runs_d;
            cause_q <= cause_d;
            tmo_q   <= tmo_d;
        end
    end

    assign runs_inc = (runs_q == 8'hFF) ? runs_q : runs_q + 8'd1;

    always_comb begin
        state_d = state_q;
        on_d    = on_q;
        off_d   = off_q;
        runs_d  = runs_q;
        cause_d = cause_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (bus.water_pump) begin
                    state_d = S_START;
                    on_d    = 8'd1;
                end
            end
            S_START: begin
                if (flow_s) begin
                    state_d = S_RUN;
                    on_d    = on_q + 8'd1;
                end else if (on_q == FLOW_WAIT_C) begin
                    state_d = S_FAULT;
                    cause_d = 2'b01;
                end else begin
                    on_d = on_q + 8'd1;
                end
            end
            S_RUN: begin
                if (!flow_s) begin
                    state_d = S_FAULT;
                    cause_d = 2'b10;
                end else if (on_q == MAX_ON_C) begin
                    state_d = S_COOL;
                    off_d   = 8'd1;
                    tmo_d   = 1'b1;
                    runs_d  = runs_inc;
                end else if (!bus.water_pump && on_q >= MIN_ON_C) begin
                    state_d = S_COOL;
                    off_d   = 8'd1;
                    runs_d  = runs_inc;
                end else begin
                    on_d = on_q + 8'd1;
                end
            end
            S_COOL: begin
                if (off_q == MIN_OFF_C) begin
                    state_d = S_OFF;
                end else begin
                    off_d = off_q + 8'd1;
                end
            end
            S_FAULT: begin
                if (bus.fault_clear) begin
                    state_d = S_COOL;
                    off_d   = 8'd1;
                    cause_d = 2'b00;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign bus.pump_en       = (state_q == S_START) || (state_q == S_RUN);
    assign bus.pump_state    = state_q;
    assign bus.fault         = (state_q == S_FAULT);
    assign bus.fault_cause   = cause_q;
    assign bus.timeout_pulse = tmo_q;
    assign bus.run_count     = runs_q;

endmodule

// File: tb/tb_pes_pump_driver.sv
// Randomized and directed bench for pes_pump_driver against a cycle-count
// reference model of the pump lifecycle.
module tb_pes_pump_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pes_pump_driver_if bus0 ();
    pes_pump_driver_if bus1 ();

    pes_pump_driver u0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0.slave)
    );

    pes_pump_driver #(
        .MIN_ON   (4),
        .MIN_OFF  (1),
        .MAX_ON   (64),
        .FLOW_WAIT(3)
    ) u1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1.slave)
    );

    // phase: 0 idle, 1 waiting for flow, 2 pumping, 3 resting, 4 faulted
    typedef struct packed {
        int phase;
        int on;
        int rest;
        bit f1;
        bit f2;
        int cause;
        bit tp;
        int runs;
    } mdl_t;

    mdl_t m0, m1;
    int n_chk = 0;
    int n_pass = 0;
    int hi_cnt, tp_cnt, runs_before;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    function automatic mdl_t step(input mdl_t m, input bit wp, input bit fs,
                                  input bit fc, input int mn, input int mo,
                                  input int mx, input int fw);
        mdl_t n = m;
        bit flow = m.f2;
        n.f1 = fs;
        n.f2 = m.f1;
        n.tp = 1'b0;
        case (m.phase)
            0: if (wp) begin n.phase = 1; n.on = 1; end
            1: begin
                if (flow) begin n.phase = 2; n.on = m.on + 1; end
                else if (m.on == fw) begin n.phase = 4; n.cause = 1; end
                else n.on = m.on + 1;
            end
            2: begin
                if (!flow) begin
                    n.phase = 4; n.cause = 2;
                end else if (m.on == mx || (!wp && m.on >= mn)) begin
                    n.phase = 3; n.rest = 1;
                    n.tp = (m.on == mx);
                    n.runs = (m.runs < 255) ? m.runs + 1 : 255;
                end else n.on = m.on + 1;
            end
            3: if (m.rest == mo) n.phase = 0; else n.rest = m.rest + 1;
            4: if (fc) begin n.phase = 3; n.rest = 1; n.cause = 0; end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    task automatic tick0(input bit wp, input bit fs, input bit fc);
        @(negedge clk);
        chk("u0_pump_en", bus0.pump_en, int'(m0.phase == 1 || m0.phase == 2));
        chk("u0_state", bus0.pump_state, m0.phase);
        chk("u0_fault", bus0.fault, int'(m0.phase == 4));
        chk("u0_cause", bus0.fault_cause, m0.cause);
        chk("u0_timeout", bus0.timeout_pulse, m0.tp);
        chk("u0_runs", bus0.run_count, m0.runs);
        if (bus0.pump_en) hi_cnt++;
        if (bus0.timeout_pulse) tp_cnt++;
        bus0.water_pump  = wp;
        bus0.flow_sensor = fs;
        bus0.fault_clear = fc;
        @(posedge clk);
        m0 = step(m0, wp, fs, fc, 8, 16, 64, 4);
    endtask

    task automatic tick1(input bit wp, input bit fs, input bit fc);
        @(negedge clk);
        chk("u1_pump_en", bus1.pump_en, int'(m1.phase == 1 || m1.phase == 2));
        chk("u1_state", bus1.pump_state, m1.phase);
        chk("u1_runs", bus1.run_count, m1.runs);
        bus1.water_pump  = wp;
        bus1.flow_sensor = fs;
        bus1.fault_clear = fc;
        @(posedge clk);
        m1 = step(m1, wp, fs, fc, 4, 1, 64, 3);
    endtask

    // Bring u0 back to idle with flow present and synchronised
    task automatic settle0();
        for (int i = 0; i < 200 && m0.phase != 0; i++) tick0(1'b0, 1'b1, 1'b1);
        tick0(1'b0, 1'b1, 1'b0);
        tick0(1'b0, 1'b1, 1'b0);
        chk("settle_idle", bus0.pump_state, 0);
    endtask

    initial begin
        bit wp, fs, fc;
        reset = 1'b1;
        bus0.water_pump = 1'b0; bus0.flow_sensor = 1'b0; bus0.fault_clear = 1'b0;
        bus1.water_pump = 1'b0; bus1.flow_sensor = 1'b0; bus1.fault_clear = 1'b0;
        m0 = '0;
        m1 = '0;
        hi_cnt = 0;
        tp_cnt = 0;
        #12;
        chk("rst_pump_en", bus0.pump_en, 0);
        chk("rst_state", bus0.pump_state, 0);
        chk("rst_fault", bus0.fault, 0);
        chk("rst_runs", bus0.run_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Short request
        repeat (3) tick0(1'b0, 1'b1, 1'b0);
        hi_cnt = 0; tp_cnt = 0;
        repeat (3) tick0(1'b1, 1'b1, 1'b0);
        repeat (30) tick0(1'b0, 1'b1, 1'b0);
        chk("short_on_cycles", hi_cnt, 8);
        chk("short_timeouts", tp_cnt, 0);
        chk("short_runs", bus0.run_count, 1);

        // No flow at start
        repeat (3) tick0(1'b0, 1'b0, 1'b0);
        hi_cnt = 0;
        repeat (55) tick0(1'b1, 1'b0, 1'b0);
        #1;
        chk("noflow_on_cycles", hi_cnt, 4);
        chk("noflow_fault", bus0.fault, 1);
        chk("noflow_cause", bus0.fault_cause, 1);
        tick0(1'b1, 1'b0, 1'b1);
        repeat (20) tick0(1'b1, 1'b0, 1'b0);

        // Timeout runs
        settle0();
        hi_cnt = 0; tp_cnt = 0;
        repeat (300) tick0(1'b1, 1'b1, 1'b0);
        chk("timeout_pulses", tp_cnt, 3);
        chk("timeout_on_cycles", hi_cnt, 248);

        // Dry run at on-cycle 20
        settle0();
        for (int i = 0; i < 100 && !(m0.phase == 2 && m0.on == 20); i++)
            tick0(1'b1, 1'b1, 1'b0);
        chk("dry_reached", bus0.pump_state, 2);
        runs_before = m0.runs;
        repeat (3) tick0(1'b1, 1'b0, 1'b0);
        #1;
        chk("dry_fault", bus0.fault, 1);
        chk("dry_cause", bus0.fault_cause, 2);
        chk("dry_pump_en", bus0.pump_en, 0);
        chk("dry_runs", bus0.run_count, runs_before);

        // Randomized traffic
        wp = 1'b0; fs = 1'b1; fc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) wp = ~wp;
            if ($urandom_range(0, 39) == 0) fs = ~fs;
            fc = ($urandom_range(0, 9) == 0);
            tick0(wp, fs, fc);
        end

        // Asynchronous reset in the middle of a run
        settle0();
        for (int i = 0; i < 100 && !(m0.phase == 2 && m0.on == 10); i++)
            tick0(1'b1, 1'b1, 1'b0);
        chk("mid_reached", bus0.pump_state, 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pump_en", bus0.pump_en, 0);
        chk("mid_rst_state", bus0.pump_state, 0);
        chk("mid_rst_runs", bus0.run_count, 0);
        chk("mid_rst_timeout", bus0.timeout_pulse, 0);
        m0 = '0;
        m1 = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick0(1'b0, 1'b1, 1'b0);

        // Run counter saturation on the short-parameter instance
        repeat (3) tick1(1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 260; r++) begin
            tick1(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < 50 && m1.phase != 0; j++) tick1(1'b0, 1'b1, 1'b0);
        end
        #1;
        chk("sat_runs", bus1.run_count, 255);
        repeat (10) tick1(1'b1, 1'b1, 1'b0);
        #1;
        chk("sat_hold", bus1.run_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
